// File: rtl/fifo_mcu_pkg.sv
// Shared constants and word packing for the MCU FIFO family.
package fifo_mcu_pkg;

    localparam int unsigned MCU_FIFO_AW  = 6;
    localparam int unsigned MCU_BYTE_W   = 8;
    localparam int unsigned MCU_WORD_W   = 16;
    localparam logic [MCU_BYTE_W-1:0] MCU_PAD_BYTE = 8'h00;

    // Byte-lane convention: the first MCU byte of a pair lands in the low lane.
    localparam logic MCU_FIRST_LANE_LO = 1'b1;

    typedef struct packed {
        logic [MCU_BYTE_W-1:0] hi;
        logic [MCU_BYTE_W-1:0] lo;
    } mcu_word_t;

    // Pack two bytes in arrival order into one word according to the lane convention.
    function automatic mcu_word_t mcu_pack(input logic [MCU_BYTE_W-1:0] first,
                                           input logic [MCU_BYTE_W-1:0] second);
        mcu_word_t w;
        if (MCU_FIRST_LANE_LO) begin
            w.lo = first;
            w.hi = second;
        end else begin
            w.lo = second;
            w.hi = first;
        end
        return w;
    endfunction

endpackage

// File: rtl/fifo_mcu_wr_pack_if.sv
// MCU byte-push / consumer word-pop bus of the MCU write FIFO.
interface fifo_mcu_wr_pack_if
    import fifo_mcu_pkg::*;
#(
    parameter int unsigned AW = MCU_FIFO_AW
);
    logic                  wr_en;
    logic [MCU_BYTE_W-1:0] wr_data;
    logic                  flush;
    logic                  wr_full;
    logic                  wr_drop;
    logic                  byte_pend;
    logic                  rd_en;
    logic [MCU_WORD_W-1:0] rd_data;
    logic                  rd_valid;
    logic                  empty;
    logic [AW:0]           level;

    // Producer/consumer side driving the FIFO.
    modport master (
        output wr_en, wr_data, flush, rd_en,
        input  wr_full, wr_drop, byte_pend, rd_data, rd_valid, empty, level
    );

    // The FIFO itself.
    modport slave (
        input  wr_en, wr_data, flush, rd_en,
        output wr_full, wr_drop, byte_pend, rd_data, rd_valid, empty, level
    );
endinterface

// File: rtl/fifo_mcu_wr_ram.sv
// 2**AW x W simple-dual-port RAM with registered read output (EMB5K sdp, 18-bit ports).
module fifo_mcu_wr_ram
    import fifo_mcu_pkg::*;
#(
    parameter int unsigned AW = MCU_FIFO_AW,
    parameter int unsigned W  = MCU_WORD_W
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [W-1:0]  wdata,
    input  logic          re,
    input  logic [AW-1:0] raddr,
    output logic [W-1:0]  rdata
);

    localparam int unsigned DEPTH = 2**AW;

    logic [W-1:0] mem [DEPTH];

    // Write port; array contents are deliberately not reset.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Read port output register; holds its value between reads.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/fifo_mcu_wr_pack.sv
// MCU write-path FIFO: packs byte pairs into 16-bit words, pops words with 1-cycle latency.
module fifo_mcu_wr_pack
    import fifo_mcu_pkg::*;
#(
    parameter int unsigned           AW       = MCU_FIFO_AW,
    parameter logic [MCU_BYTE_W-1:0] PAD_BYTE = MCU_PAD_BYTE
) (
    input  logic              clk,
    input  logic              rstn,
    fifo_mcu_wr_pack_if.slave bus
);

    localparam int unsigned DEPTH    = 2**AW;
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [AW-1:0]         wptr;
    logic [AW-1:0]         rptr;
    logic [AW:0]           count;
    logic                  half_vld;
    logic [MCU_BYTE_W-1:0] half_byte;
    logic                  flush_pend;
    logic                  wr_drop;
    logic                  rd_valid;

    logic                  full_c;
    logic                  empty_c;
    logic                  accept_c;
    logic                  byte_wr_c;
    logic                  pad_wr_c;
    logic                  push_c;
    logic                  pop_c;
    mcu_word_t             wword_c;

    // Handshake decode from registered state; byte completion and pad write are exclusive.
    always_comb begin
        full_c    = (count == FULL_CNT);
        empty_c   = (count == '0);
        accept_c  = bus.wr_en & ~full_c;
        byte_wr_c = accept_c & half_vld;
        pad_wr_c  = flush_pend & ~accept_c & half_vld & ~full_c;
        push_c    = byte_wr_c | pad_wr_c;
        pop_c     = bus.rd_en & ~empty_c;
        wword_c   = byte_wr_c ? mcu_pack(half_byte, bus.wr_data)
                              : mcu_pack(half_byte, PAD_BYTE);
    end

    // Pack register, flush tracking, pointers, count and status pulses.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            wptr       <= '0;
            rptr       <= '0;
            count      <= '0;
            half_vld   <= 1'b0;
            half_byte  <= '0;
            flush_pend <= 1'b0;
            wr_drop    <= 1'b0;
            rd_valid   <= 1'b0;
        end else begin
            if (accept_c) begin
                if (half_vld) begin
                    half_vld <= 1'b0;
                end else begin
                    half_byte <= bus.wr_data;
                    half_vld  <= 1'b1;
                end
            end else if (pad_wr_c) begin
                half_vld <= 1'b0;
            end

            // A normal word completion or the pad write retires a pending flush.
            if (byte_wr_c || pad_wr_c) begin
                flush_pend <= 1'b0;
            end else if (bus.flush && (half_vld || accept_c)) begin
                flush_pend <= 1'b1;
            end

            if (push_c) begin
                wptr <= wptr + AW'(1);
            end
            if (pop_c) begin
                rptr <= rptr + AW'(1);
            end

            unique case ({push_c, pop_c})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase

            wr_drop  <= bus.wr_en & full_c;
            rd_valid <= pop_c;
        end
    end

    fifo_mcu_wr_ram #(
        .AW (AW),
        .W  (MCU_WORD_W)
    ) u_ram (
        .clk   (clk),
        .rstn  (rstn),
        .we    (push_c),
        .waddr (wptr),
        .wdata (wword_c),
        .re    (pop_c),
        .raddr (rptr),
        .rdata (bus.rd_data)
    );

    // Status flags derived from registered state.
    always_comb begin
        bus.wr_full   = full_c;
        bus.empty     = empty_c;
        bus.level     = count;
        bus.byte_pend = half_vld;
        bus.wr_drop   = wr_drop;
        bus.rd_valid  = rd_valid;
    end

endmodule

// File: tb/tb_fifo_mcu_wr_pack.sv
// Self-checking bench for fifo_mcu_wr_pack: vector table plus scoreboarded sequences.
module tb_fifo_mcu_wr_pack;
    import fifo_mcu_pkg::*;

    typedef struct {
        logic        we;
        logic [7:0]  wd;
        logic        fl;
        logic        re;
        logic [6:0]  lvl;
        logic        pend;
        logic        vld;
        logic [15:0] word;
    } vec_t;

    logic clk;
    logic rstn;

    fifo_mcu_wr_pack_if ifc ();

    fifo_mcu_wr_pack dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (ifc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          nvec = 0;
    int          nmis = 0;
    logic [15:0] sb[$];
    logic [15:0] stored[$];
    logic [7:0]  mhalf = 8'h00;
    logic        mpend = 1'b0;
    vec_t        vt[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nmis++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic we, input logic [7:0] wd, input logic fl, input logic re);
        ifc.wr_en   = we;
        ifc.wr_data = wd;
        ifc.flush   = fl;
        ifc.rd_en   = re;
        @(posedge clk);
        #1;
        ifc.wr_en   = 1'b0;
        ifc.wr_data = 8'h00;
        ifc.flush   = 1'b0;
        ifc.rd_en   = 1'b0;
    endtask

    task automatic sample(input logic [6:0] lvl, input logic pend, input logic vld, input logic drop);
        check("level", 32'(ifc.level), 32'(lvl));
        check("byte_pend", 32'(ifc.byte_pend), 32'(pend));
        check("empty", 32'(ifc.empty), 32'(lvl == 7'd0));
        check("wr_full", 32'(ifc.wr_full), 32'(lvl == 7'd64));
        check("rd_valid", 32'(ifc.rd_valid), 32'(vld));
        check("wr_drop", 32'(ifc.wr_drop), 32'(drop));
        if (ifc.rd_valid === 1'b1) begin
            if (sb.size() == 0) begin
                nvec++;
                nmis++;
                $display("FAIL rd_data: unexpected word %0h, scoreboard empty", ifc.rd_data);
            end else begin
                check("rd_data", 32'(ifc.rd_data), 32'(sb.pop_front()));
            end
        end
    endtask

    // Byte/pop step against the queue-based reference (no flush).
    task automatic mstep(input logic we, input logic [7:0] wd, input logic re);
        int   cnt;
        logic exp_vld;
        logic exp_drop;
        cnt      = stored.size();
        exp_vld  = re && (cnt > 0);
        exp_drop = we && (cnt == 64);
        if (exp_vld) sb.push_back(stored.pop_front());
        if (we && cnt != 64) begin
            if (mpend) begin
                stored.push_back({wd, mhalf});
                mpend = 1'b0;
            end else begin
                mhalf = wd;
                mpend = 1'b1;
            end
        end
        drive(we, wd, 1'b0, re);
        sample(7'(stored.size()), mpend, exp_vld, exp_drop);
    endtask

    initial begin
        ifc.wr_en   = 1'b0;
        ifc.wr_data = 8'h00;
        ifc.flush   = 1'b0;
        ifc.rd_en   = 1'b0;
        rstn        = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rstn = 1'b1;
        sample(7'd0, 1'b0, 1'b0, 1'b0);
        check("reset rd_data", 32'(ifc.rd_data), 32'h0);

        //           we    wd     fl    re    lvl   pend  vld   word
        vt.push_back('{1'b1, 8'h11, 1'b0, 1'b0, 7'd0, 1'b1, 1'b0, 16'h0000});
        vt.push_back('{1'b1, 8'h22, 1'b0, 1'b0, 7'd1, 1'b0, 1'b0, 16'h0000});
        vt.push_back('{1'b1, 8'h33, 1'b0, 1'b0, 7'd1, 1'b1, 1'b0, 16'h0000});
        vt.push_back('{1'b1, 8'h44, 1'b0, 1'b0, 7'd2, 1'b0, 1'b0, 16'h0000});
        vt.push_back('{1'b0, 8'h00, 1'b0, 1'b1, 7'd1, 1'b0, 1'b1, 16'h2211});
        vt.push_back('{1'b0, 8'h00, 1'b0, 1'b1, 7'd0, 1'b0, 1'b1, 16'h4433});
        vt.push_back('{1'b0, 8'h00, 1'b0, 1'b1, 7'd0, 1'b0, 1'b0, 16'h0000});
        // odd byte then flush: pad word
        vt.push_back('{1'b1, 8'hA5, 1'b0, 1'b0, 7'd0, 1'b1, 1'b0, 16'h0000});
        vt.push_back('{1'b0, 8'h00, 1'b1, 1'b0, 7'd0, 1'b1, 1'b0, 16'h0000});
        vt.push_back('{1'b0, 8'h00, 1'b0, 1'b0, 7'd1, 1'b0, 1'b0, 16'h0000});
        vt.push_back('{1'b0, 8'h00, 1'b0, 1'b1, 7'd0, 1'b0, 1'b1, 16'h00A5});
        // flush with nothing pending is ignored
        vt.push_back('{1'b0, 8'h00, 1'b1, 1'b0, 7'd0, 1'b0, 1'b0, 16'h0000});
        vt.push_back('{1'b0, 8'h00, 1'b0, 1'b0, 7'd0, 1'b0, 1'b0, 16'h0000});
        // flush with first byte, second byte completes normally: no pad
        vt.push_back('{1'b1, 8'h5A, 1'b1, 1'b0, 7'd0, 1'b1, 1'b0, 16'h0000});
        vt.push_back('{1'b1, 8'h6B, 1'b0, 1'b0, 7'd1, 1'b0, 1'b0, 16'h0000});
        vt.push_back('{1'b0, 8'h00, 1'b0, 1'b0, 7'd1, 1'b0, 1'b0, 16'h0000});
        vt.push_back('{1'b0, 8'h00, 1'b0, 1'b1, 7'd0, 1'b0, 1'b1, 16'h6B5A});
        // flush together with the completing byte: no pad
        vt.push_back('{1'b1, 8'h01, 1'b0, 1'b0, 7'd0, 1'b1, 1'b0, 16'h0000});
        vt.push_back('{1'b1, 8'h02, 1'b1, 1'b0, 7'd1, 1'b0, 1'b0, 16'h0000});
        vt.push_back('{1'b0, 8'h00, 1'b0, 1'b0, 7'd1, 1'b0, 1'b0, 16'h0000});
        vt.push_back('{1'b0, 8'h00, 1'b0, 1'b1, 7'd0, 1'b0, 1'b1, 16'h0201});
        vt.push_back('{1'b0, 8'h00, 1'b0, 1'b0, 7'd0, 1'b0, 1'b0, 16'h0000});

        for (int i = 0; i < vt.size(); i++) begin
            if (vt[i].vld) sb.push_back(vt[i].word);
            drive(vt[i].we, vt[i].wd, vt[i].fl, vt[i].re);
            sample(vt[i].lvl, vt[i].pend, vt[i].vld, 1'b0);
        end

        // Fill to full, drop on overflow, free one slot, refill, then drain back-to-back.
        for (int i = 0; i < 128; i++) mstep(1'b1, 8'(i), 1'b0);
        mstep(1'b1, 8'h77, 1'b0);
        mstep(1'b0, 8'h00, 1'b1);
        mstep(1'b1, 8'hC1, 1'b0);
        mstep(1'b1, 8'hC2, 1'b0);
        mstep(1'b1, 8'h99, 1'b0);
        for (int i = 0; i < 64; i++) mstep(1'b0, 8'h00, 1'b1);
        mstep(1'b0, 8'h00, 1'b1);

        // Steady stream across pointer wrap: pop on every other cycle.
        for (int k = 0; k < 70; k++) begin
            mstep(1'b1, 8'(2 * k + 3), 1'b1);
            mstep(1'b1, 8'(8'hF0 ^ 8'(k)), 1'b0);
        end
        mstep(1'b0, 8'h00, 1'b1);

        // Reset mid-stream with a pending byte and ten stored words.
        for (int i = 0; i < 21; i++) mstep(1'b1, 8'(8'h40 + 8'(i)), 1'b0);
        rstn      = 1'b0;
        ifc.rd_en = 1'b1;
        @(posedge clk);
        #1;
        rstn      = 1'b1;
        ifc.rd_en = 1'b0;
        stored.delete();
        mpend = 1'b0;
        sample(7'd0, 1'b0, 1'b0, 1'b0);
        check("post-reset rd_data", 32'(ifc.rd_data), 32'h0);
        mstep(1'b0, 8'h00, 1'b1);
        check("sb drained", 32'(sb.size()), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end

endmodule
